acq_seq: RTL and testbench
==========================

ACQ_SEQ -- requirements
Module: acq_seq

Interface
REQ-001 Parameter NW, default 16, width of the acquisition-count configuration and status.
REQ-002 Parameter TW, default 32, width of the timeout/holdoff counter and configuration.
REQ-003 Port clk  in  1  single clock; all logic SHALL be synchronous to its rising edge.
REQ-004 Port rst  in  1  reset, asynchronous and active-high.
REQ-005 Port ctl_run  in  1  start-sequence pulse.
REQ-006 Port ctl_abt  in  1  abort pulse.
REQ-007 Port cfg_num  in  NW  acquisitions per sequence; 0 means continuous.
REQ-008 Port cfg_dly  in  TW  holdoff cycles between acquisitions.
REQ-009 Port cfg_tmo  in  TW  trigger timeout in cycles; 0 disables the timeout.
REQ-010 Port sts_trg  in  1  trigger-accepted status from the acquisition block.
REQ-011 Port sts_lst  in  1  last-sample pulse from the acquisition block.
REQ-012 Port evo  out  evn_pkg::evn_t  event pulses (rst, str, stp, swt) to the acquisition block.
REQ-013 Port sts_run  out  1  a sequence is active.
REQ-014 Port sts_cnt  out  NW  completed acquisitions in the current sequence.
REQ-015 Port sts_abt  out  1  sticky flag: the last sequence was aborted.
REQ-016 Port irq  out  1  one-cycle pulse when a finite sequence completes.

Function
REQ-017 States SHALL be IDLE, RST, ARM, WTRG, WLST and HOLD, held in a single state register.
REQ-018 IDLE: ctl_run=1 SHALL clear sts_cnt and sts_abt, set sts_run, and go to RST.
REQ-019 RST: the block SHALL drive evo.rst=1 for exactly one cycle, then go to ARM.
REQ-020 ARM: the block SHALL drive evo.str=1 for one cycle, clear the shared counter, and go to WTRG.
REQ-021 WTRG: sts_trg=1 SHALL go to WLST without a swt pulse.
REQ-022 WTRG: with cfg_tmo!=0 and counter==cfg_tmo-1, the block SHALL drive evo.swt=1 for one cycle and go to WLST; otherwise it SHALL increment the counter.
REQ-023 WTRG: if sts_trg and the timeout occur in the same cycle, sts_trg SHALL win and no swt is issued.
REQ-024 WLST or WTRG: sts_lst=1 SHALL increment sts_cnt (wrapping modulo 2^NW when cfg_num=0).
REQ-025 After that increment, if cfg_num!=0 and the new count equals cfg_num, the block SHALL pulse irq, clear sts_run, and go to IDLE; otherwise it SHALL clear the counter and go to HOLD.
REQ-026 HOLD: the counter SHALL increment each cycle; when counter>=cfg_dly the block SHALL go to RST, so cfg_dly=0 gives RST on the next cycle.
REQ-027 Abort: ctl_abt=1 in any non-IDLE state SHALL have priority over all other transitions.
REQ-028 On abort the block SHALL drive evo.stp=1 for one cycle, set sts_abt, clear sts_run, go to IDLE, and leave sts_cnt unchanged.
REQ-029 ctl_abt in IDLE and ctl_run outside IDLE SHALL be ignored.
REQ-030 All outputs SHALL be registered; each evo field is a pulse issued one cycle after the state/condition that causes it, and at most one evo field is high per cycle.
REQ-031 cfg_* inputs SHALL be sampled each cycle (no shadowing); a change takes effect on the next comparison.

Reset
REQ-032 On rst the state SHALL be IDLE, evo='0, sts_run=0, sts_cnt=0, sts_abt=0, irq=0, and the counter=0.
REQ-033 rst asserted mid-sequence SHALL return the block to IDLE immediately without any stp pulse.

Structure
REQ-034 The state enum SHALL live in acq_seq_pkg; evn_t SHALL be reused from evn_pkg.
REQ-035 A single TW-bit counter SHALL be shared between WTRG and HOLD, and no sub-module is required.

Verification
REQ-036 cfg_num=2, cfg_dly=3, cfg_tmo=0, sts_trg after 5 cycles, sts_lst 10 cycles later -> rst, str pulses twice; 3-cycle HOLD gap; sts_cnt=2; one irq; sts_run=0.
REQ-037 cfg_tmo=8, no sts_trg -> evo.swt exactly 8 cycles after the str pulse; state WLST.
REQ-038 cfg_tmo=8 with sts_trg in the 8th cycle -> no swt.
REQ-039 cfg_num=0 run for 4 acquisitions, then ctl_abt in HOLD -> stp pulse, sts_abt=1, sts_cnt=4, no irq.
REQ-040 ctl_abt and sts_lst in the same cycle in WLST -> stp issued, sts_cnt unchanged.
REQ-041 rst asserted in WTRG -> all outputs 0 asynchronously; no stp; a following ctl_run restarts from RST.

Source files
------------

// File: rtl/acq_seq_pkg.sv
// Types for the acquisition sequencer.
// state_t enumerates the sequencer states:
//   IDLE - no sequence active
//   RST  - reset the acquisition block
//   ARM  - start the acquisition block
//   WTRG - wait for a trigger (optionally with timeout)
//   WLST - wait for the last sample of the acquisition
//   HOLD - holdoff delay between acquisitions
package acq_seq_pkg;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RST  = 3'd1,
    ARM  = 3'd2,
    WTRG = 3'd3,
    WLST = 3'd4,
    HOLD = 3'd5
  } state_t;

endpackage

// File: rtl/evn_pkg.sv
// Event-pulse bundle shared between sequencers and the acquisition block.
// evn_t carries four single-cycle strobes:
//   rst - reset the acquisition block before a new acquisition
//   str - start (arm) an acquisition
//   stp - stop an acquisition in progress (abort)
//   swt - software trigger, issued when no hardware trigger arrives in time
package evn_pkg;

  typedef struct packed {
    logic rst;
    logic str;
    logic stp;
    logic swt;
  } evn_t;

endpackage

// File: rtl/acq_seq.sv
// Acquisition sequencer: runs a sequence of acquisitions on an external
// acquisition block (reset, start, wait trigger, wait last sample, holdoff).
// Ports:
//   clk, rst          - clock, asynchronous active-high reset
//   ctl_run, ctl_abt  - start-sequence and abort pulses
//   cfg_num           - acquisitions per sequence (0 = continuous)
//   cfg_dly           - holdoff cycles between acquisitions
//   cfg_tmo           - trigger timeout in cycles (0 = no timeout)
//   sts_trg, sts_lst  - trigger accepted / last sample, from the acquisition block
//   evo               - registered event pulses to the acquisition block
//   sts_run           - sequence active
//   sts_cnt           - acquisitions completed in the current sequence
//   sts_abt           - sticky: last sequence was aborted
//   irq               - one-cycle pulse when a finite sequence completes
module acq_seq
  import acq_seq_pkg::*;
#(
  parameter int NW = 16,
  parameter int TW = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ctl_run,
  input  logic              ctl_abt,
  input  logic [NW-1:0]     cfg_num,
  input  logic [TW-1:0]     cfg_dly,
  input  logic [TW-1:0]     cfg_tmo,
  input  logic              sts_trg,
  input  logic              sts_lst,
  output evn_pkg::evn_t     evo,
  output logic              sts_run,
  output logic [NW-1:0]     sts_cnt,
  output logic              sts_abt,
  output logic              irq
);

  state_t        state, state_nxt;
  logic [TW-1:0] ctr, ctr_nxt;
  evn_pkg::evn_t evo_nxt;
  logic          run_nxt, abt_nxt, irq_nxt;
  logic [NW-1:0] cnt_nxt, cnt_inc;
  logic          abort, fin, tmo_hit;

  // Abort only matters while a sequence is active.
  assign abort   = ctl_abt && (state != IDLE);
  // Count after this acquisition; wraps naturally in continuous mode.
  assign cnt_inc = sts_cnt + NW'(1);
  assign fin     = (cfg_num != '0) && (cnt_inc == cfg_num);
  assign tmo_hit = (cfg_tmo != '0) && (ctr == cfg_tmo - TW'(1));

  // State register, shared counter and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      ctr     <= '0;
      evo     <= '0;
      sts_run <= 1'b0;
      sts_cnt <= '0;
      sts_abt <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_nxt;
      ctr     <= ctr_nxt;
      evo     <= evo_nxt;
      sts_run <= run_nxt;
      sts_cnt <= cnt_nxt;
      sts_abt <= abt_nxt;
      irq     <= irq_nxt;
    end
  end

  // Next state and shared counter.
  always_comb begin
    state_nxt = state;
    ctr_nxt   = ctr;
    if (abort) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (ctl_run) state_nxt = RST;
        RST:  state_nxt = ARM;
        ARM: begin
          state_nxt = WTRG;
          ctr_nxt   = '0;
        end
        WTRG: begin
          // A last sample implies the trigger already happened.
          if (sts_lst) begin
            state_nxt = fin ? IDLE : HOLD;
            ctr_nxt   = '0;
          end else if (sts_trg || tmo_hit) begin
            state_nxt = WLST;
          end else begin
            ctr_nxt = ctr + TW'(1);
          end
        end
        WLST: begin
          if (sts_lst) begin
            state_nxt = fin ? IDLE : HOLD;
            ctr_nxt   = '0;
          end
        end
        HOLD: begin
          // Compared before incrementing, so cfg_dly=0 leaves after one cycle.
          if (ctr >= cfg_dly) state_nxt = RST;
          else                ctr_nxt   = ctr + TW'(1);
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Next values of the registered outputs.
  always_comb begin
    evo_nxt = '0;
    run_nxt = sts_run;
    cnt_nxt = sts_cnt;
    abt_nxt = sts_abt;
    irq_nxt = 1'b0;
    if (abort) begin
      evo_nxt.stp = 1'b1;
      abt_nxt     = 1'b1;
      run_nxt     = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ctl_run) begin
            cnt_nxt = '0;
            abt_nxt = 1'b0;
            run_nxt = 1'b1;
          end
        end
        RST: evo_nxt.rst = 1'b1;
        ARM: evo_nxt.str = 1'b1;
        WTRG, WLST: begin
          if (sts_lst) begin
            cnt_nxt = cnt_inc;
            if (fin) begin
              irq_nxt = 1'b1;
              run_nxt = 1'b0;
            end
          end else if ((state == WTRG) && !sts_trg && tmo_hit) begin
            evo_nxt.swt = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_acq_seq.sv
module tb_acq_seq;
  import acq_seq_pkg::*;

  localparam int NW = 16;
  localparam int TW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ctl_run, ctl_abt, sts_trg, sts_lst;
  logic [NW-1:0] cfg_num;
  logic [TW-1:0] cfg_dly, cfg_tmo;
  evn_pkg::evn_t evo;
  logic          sts_run, sts_abt, irq;
  logic [NW-1:0] sts_cnt;

  int n_chk = 0, n_err = 0;
  int n_rst = 0, n_str = 0, n_stp = 0, n_swt = 0, n_irq = 0;
  int stp_before;

  acq_seq #(.NW(NW), .TW(TW)) dut (
    .clk(clk), .rst(rst),
    .ctl_run(ctl_run), .ctl_abt(ctl_abt),
    .cfg_num(cfg_num), .cfg_dly(cfg_dly), .cfg_tmo(cfg_tmo),
    .sts_trg(sts_trg), .sts_lst(sts_lst),
    .evo(evo), .sts_run(sts_run), .sts_cnt(sts_cnt),
    .sts_abt(sts_abt), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Pulse counters and one-hot check on the event bus.
  always @(posedge clk) begin
    #1;
    if (evo.rst) n_rst++;
    if (evo.str) n_str++;
    if (evo.stp) n_stp++;
    if (evo.swt) n_swt++;
    if (irq)     n_irq++;
    if (evo != '0) chk("evo_onehot", 64'($countones(evo)), 64'd1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; ctl_run = 0; ctl_abt = 0; sts_trg = 0; sts_lst = 0;
    cfg_num = '0; cfg_dly = '0; cfg_tmo = '0;
    step(2);
    chk("rst_evo", evo, 0);
    chk("rst_run", sts_run, 0);
    chk("rst_cnt", sts_cnt, 0);
    chk("rst_abt", sts_abt, 0);
    chk("rst_irq", irq, 0);
    chk("rst_state", dut.state, IDLE);
    rst = 1'b0;
    step(1);

    // Abort in IDLE is ignored
    ctl_abt = 1; step(1); ctl_abt = 0; step(1);
    chk("idle_abt_flag", sts_abt, 0);
    chk("idle_abt_stp", n_stp, 0);
    chk("idle_abt_state", dut.state, IDLE);

    // Two-acquisition finite sequence, holdoff 3, no timeout
    cfg_num = 2; cfg_dly = 3; cfg_tmo = 0;
    ctl_run = 1; step(1); ctl_run = 0;
    chk("t1_run", sts_run, 1);
    chk("t1_cnt0", sts_cnt, 0);
    step(1); chk("t1_rst_a", evo.rst, 1);
    step(1); chk("t1_str_a", evo.str, 1);
    step(2); ctl_run = 1; step(1); ctl_run = 0;   // ignored outside IDLE
    step(2); sts_trg = 1; step(1); sts_trg = 0;
    chk("t1_wlst", dut.state, WLST);
    step(9); sts_lst = 1; step(1); sts_lst = 0;
    chk("t1_cnt1", sts_cnt, 1);
    chk("t1_hold", dut.state, HOLD);
    chk("t1_nrst1", n_rst, 1);
    step(4); chk("t1_gap_norst", evo.rst, 0);
    step(1); chk("t1_rst_b", evo.rst, 1);
    step(1); chk("t1_str_b", evo.str, 1);
    step(5); sts_trg = 1; step(1); sts_trg = 0;
    step(9); sts_lst = 1; step(1); sts_lst = 0;
    chk("t1_cnt2", sts_cnt, 2);
    chk("t1_irq", irq, 1);
    chk("t1_run_off", sts_run, 0);
    chk("t1_idle", dut.state, IDLE);
    step(1);
    chk("t1_irq_pulse", irq, 0);
    chk("t1_nrst", n_rst, 2);
    chk("t1_nstr", n_str, 2);
    chk("t1_nirq", n_irq, 1);

    // Timeout of 8 with no trigger, then abort coinciding with last sample
    cfg_num = 0; cfg_tmo = 8;
    ctl_run = 1; step(1); ctl_run = 0;
    step(1); step(1); chk("t2_str", evo.str, 1);
    step(7); chk("t2_swt_early", evo.swt, 0);
    step(1); chk("t2_swt", evo.swt, 1);
    chk("t2_wlst", dut.state, WLST);
    ctl_abt = 1; sts_lst = 1; step(1); ctl_abt = 0; sts_lst = 0;
    chk("t2_stp", evo.stp, 1);
    chk("t2_cnt_hold", sts_cnt, 0);
    chk("t2_abt", sts_abt, 1);
    chk("t2_run_off", sts_run, 0);
    chk("t2_idle", dut.state, IDLE);

    // Trigger in the same cycle as the timeout wins
    ctl_run = 1; step(1); ctl_run = 0;
    chk("t3_abt_clr", sts_abt, 0);
    step(1); step(1); chk("t3_str", evo.str, 1);
    step(7); sts_trg = 1; step(1); sts_trg = 0;
    chk("t3_noswt", evo.swt, 0);
    chk("t3_wlst", dut.state, WLST);
    step(3);
    chk("t3_nswt", n_swt, 1);
    ctl_abt = 1; step(1); ctl_abt = 0;
    chk("t3_stp", evo.stp, 1);

    // Continuous mode, zero holdoff, four acquisitions, abort in HOLD
    cfg_num = 0; cfg_tmo = 0; cfg_dly = 0;
    ctl_run = 1; step(1); ctl_run = 0;
    chk("t4_cnt_clr", sts_cnt, 0);
    chk("t4_abt_clr", sts_abt, 0);
    step(1); step(1); chk("t4_str", evo.str, 1);
    for (int i = 0; i < 4; i++) begin
      sts_trg = 1; step(1); sts_trg = 0;
      sts_lst = 1; step(1); sts_lst = 0;
      chk("t4_cnt", sts_cnt, 64'(i + 1));
      if (i < 3) begin
        step(2); chk("t4_rst", evo.rst, 1);
        step(1); chk("t4_str_n", evo.str, 1);
      end
    end
    chk("t4_hold", dut.state, HOLD);
    ctl_abt = 1; step(1); ctl_abt = 0;
    chk("t4_stp", evo.stp, 1);
    chk("t4_abt", sts_abt, 1);
    chk("t4_cnt4", sts_cnt, 4);
    chk("t4_noirq", n_irq, 1);
    chk("t4_run_off", sts_run, 0);

    // Asynchronous reset while waiting for a trigger
    step(1);
    ctl_run = 1; step(1); ctl_run = 0;
    step(1); step(1); chk("t5_str", evo.str, 1);
    step(2);
    chk("t5_wtrg", dut.state, WTRG);
    stp_before = n_stp;
    #2 rst = 1;
    #1;
    chk("t5_async_run", sts_run, 0);
    chk("t5_async_evo", evo, 0);
    chk("t5_async_cnt", sts_cnt, 0);
    chk("t5_async_state", dut.state, IDLE);
    @(negedge clk); rst = 0;
    step(2);
    chk("t5_nostp", n_stp, stp_before);
    ctl_run = 1; step(1); ctl_run = 0;
    chk("t5_run", sts_run, 1);
    step(1); chk("t5_rst", evo.rst, 1);
    step(1); chk("t5_str2", evo.str, 1);
    ctl_abt = 1; step(1); ctl_abt = 0;
    step(1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
